seq_detector_param: RTL and testbench

Parametrised serial bit-sequence detector, the generalisation of the fixed-pattern overlapping detector.
- Pattern value, pattern length (1..MAX_LEN) and overlap/non-overlap mode are runtime-loadable.
- Input is qualified by a valid strobe; a registered one-cycle pulse flags each match.
- Sits on a serial input stream ahead of protocol/framing logic.

---
 rtl/seq_detector_param.sv | 98 +++++++++
 tb/tb_seq_detector_param.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_detector_param: runtime-loadable serial pattern detector; the        |
// | SEQDET_COUNT_EN macro adds a saturating match counter. Rev 1.0           |
// +--------------------------------------------------------------------------+
module seq_detector_param #(
  parameter int                 MAX_LEN         = 8,
  parameter int                 LEN_W           = $clog2(MAX_LEN + 1),
  parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'(8'b0000_1011),
  parameter int                 DEFAULT_LEN     = 4,
`ifdef SEQDET_COUNT_EN
  parameter int                 CNT_W           = 16,
`endif
  parameter bit                 DEFAULT_OVERLAP = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               x_valid,
  input  logic               x,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
`ifdef SEQDET_COUNT_EN
  output logic [CNT_W-1:0]   match_count,
`endif
  output logic               detected
);

  localparam logic [LEN_W-1:0] c_max_len = LEN_W'(MAX_LEN);

  logic [MAX_LEN-2:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic               r_ovl;
  logic               r_detected;

  logic [MAX_LEN-1:0] w_hist_n;
  logic [MAX_LEN-1:0] w_mask;
  logic [LEN_W-1:0]   w_fill_inc;
  logic [LEN_W-1:0]   w_cfg_len;
  logic               w_match;

  // History only needs MAX_LEN-1 bits: the newest bit completes the window.
  assign w_hist_n   = {r_hist, x};
  assign w_mask     = ~({MAX_LEN{1'b1}} << r_len);
  assign w_fill_inc = (r_fill == c_max_len) ? r_fill : r_fill + 1'b1;
  assign w_match    = (w_fill_inc >= r_len) && (((w_hist_n ^ r_pat) & w_mask) == '0);

  assign w_cfg_len  = (cfg_len == '0)       ? LEN_W'(1)  :
                      (cfg_len > c_max_len) ? c_max_len  : cfg_len;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hist     <= '0;
      r_fill     <= '0;
      r_pat      <= DEFAULT_PATTERN;
      r_len      <= LEN_W'(DEFAULT_LEN);
      r_ovl      <= DEFAULT_OVERLAP;
      r_detected <= 1'b0;
    end else if (cfg_load) begin
      r_hist     <= '0;
      r_fill     <= '0;
      r_pat      <= cfg_pattern;
      r_len      <= w_cfg_len;
      r_ovl      <= cfg_overlap;
      r_detected <= 1'b0;
    end else if (x_valid) begin
      r_hist     <= w_hist_n[MAX_LEN-2:0];
      // Non-overlap match drops back to filling; overlap keeps the suffix live.
      r_fill     <= (w_match && !r_ovl) ? '0 : w_fill_inc;
      r_detected <= w_match;
    end else begin
      r_detected <= 1'b0;
    end
  end

  assign detected = r_detected;

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (cfg_load) begin
      r_cnt <= '0;
    end else if (x_valid && w_match && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign match_count = r_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// Scoreboard bench for seq_detector_param: directed scenarios plus random
// traffic checked against a bit-queue reference model.
module tb_seq_detector_param;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               x_valid = 1'b0;
  logic               x = 1'b0;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               detected;
`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0]   match_count;
`endif

  seq_detector_param #(
    .MAX_LEN(MAX_LEN)
`ifdef SEQDET_COUNT_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .x_valid    (x_valid),
    .x          (x),
    .cfg_load   (cfg_load),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
`ifdef SEQDET_COUNT_EN
    .match_count(match_count),
`endif
    .detected   (detected)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             det;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;

  // Reference model: bits received since the last clear, newest at the back.
  bit               mbits[$];
  int               mlen;
  logic [MAX_LEN-1:0] mpat;
  bit               movl;
  int               mcnt;

  function automatic void mdefault();
    mpat = 8'h0B;
    mlen = 4;
    movl = 1'b1;
    mbits.delete();
    mcnt = 0;
  endfunction

  function automatic void push(input bit d);
    exp_t t;
    t.det = d;
    t.cnt = CNT_W'(mcnt);
    sb.push_back(t);
  endfunction

  function automatic bit msample(input bit b);
    bit hit;
    mbits.push_back(b);
    if (mbits.size() > MAX_LEN) void'(mbits.pop_front());
    hit = (mbits.size() >= mlen);
    for (int i = 0; i < mlen && hit; i++)
      if (mbits[mbits.size() - 1 - i] != mpat[i]) hit = 1'b0;
    if (hit) begin
      if (!movl) mbits.delete();
      if (mcnt < (1 << CNT_W) - 1) mcnt++;
    end
    return hit;
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (detected !== e.det) begin
        failures++;
        $display("FAIL detected t=%0t got=%b exp=%b", $time, detected, e.det);
      end
`ifdef SEQDET_COUNT_EN
      checks++;
      if (match_count !== e.cnt) begin
        failures++;
        $display("FAIL match_count t=%0t got=%0d exp=%0d", $time, match_count, e.cnt);
      end
`endif
    end
  end

  task automatic step(input bit v, input bit b);
    bit hit;
    x_valid  = v;
    x        = b;
    cfg_load = 1'b0;
    @(posedge clk);
    #1;
    hit = v ? msample(b) : 1'b0;
    push(hit);
  endtask

  task automatic bits(input logic [15:0] seq, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b1, seq[i]);
  endtask

  task automatic load(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                      input bit o, input bit b);
    cfg_load    = 1'b1;
    x_valid     = 1'b1;
    x           = b;
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
    x_valid  = 1'b0;
    mpat = p;
    mlen = (l == 0) ? 1 : (l > MAX_LEN) ? MAX_LEN : int'(l);
    movl = o;
    mbits.delete();
    mcnt = 0;
    push(1'b0);
  endtask

  // Asynchronous reset between edges: the pulse pending for this cycle is cleared.
  task automatic do_reset();
    if (sb.size() > 0) void'(sb.pop_back());
    rst_n = 1'b0;
    mdefault();
    push(1'b0);
    @(posedge clk);
    #1;
    push(1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    mdefault();
    @(posedge clk);
    #1;
    do_reset();

    // Defaults, overlapping: pulses after bits 4 and 7.
    bits(16'b1011011, 7);
    step(1'b0, 1'b0);

    // Non-overlap: only the first occurrence.
    load(8'h0B, 4'd4, 1'b0, 1'b0);
    bits(16'b1011011, 7);

    // Length 8 with an idle gap mid-stream.
    load(8'hA5, 4'd8, 1'b1, 1'b1);
    bits(16'b1010, 4);
    repeat (3) step(1'b0, 1'b1);
    bits(16'b0101, 4);
    step(1'b0, 1'b0);

    // Reset mid-sequence discards the partial history.
    do_reset();
    bits(16'b101, 3);
    do_reset();
    step(1'b1, 1'b1);
    bits(16'b1011, 4);

    // Config reload with unchanged settings still clears history.
    bits(16'b101, 3);
    load(8'h0B, 4'd4, 1'b1, 1'b1);
    bits(16'b1011, 4);

    // Length clamps and counter saturation.
    load(8'h01, 4'd0, 1'b1, 1'b1);
    bits(16'b1101, 4);
    bits(16'b11, 2);
    load(8'hA5, 4'd15, 1'b1, 1'b0);
    bits(16'b1010_0101, 8);
    bits(16'b1010_0101, 8);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r < 5) begin
        load(MAX_LEN'($urandom),
             ($urandom_range(0, 9) < 7) ? LEN_W'($urandom_range(1, 3))
                                        : LEN_W'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else if (r < 7) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
      end
    end

    repeat (2) step(1'b0, 1'b0);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
